// File: rtl/dm_pkg.sv
// Shared types and constants for the dm_hs data-memory slave.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  localparam int unsigned BYTE_OFS_W = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } dm_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
  } dm_op_t;

  function automatic int unsigned dm_words(input int unsigned addr_w);
    return 32'd1 << (addr_w - BYTE_OFS_W);
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational byte-lane formatting: store enables/replication, load
// extraction/extension and misalignment detection.
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] ldata_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    misaligned_o = 1'b0;
    be_o         = 4'b0000;
    wword_o      = wdata_i;
    ldata_o      = rword_i;
    byte_sel     = rword_i[7:0];
    half_sel     = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    case (addr_lo_i)
      2'd0:    byte_sel = rword_i[7:0];
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase

    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        misaligned_o = addr_lo_i[0];
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o      = {2{wdata_i[15:0]}};
        ldata_o      = {{16{sext_i & half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        misaligned_o = (addr_lo_i != 2'b00);
        be_o         = 4'b1111;
      end
      default: misaligned_o = 1'b1;
    endcase

    // A rejected access must never touch the array.
    if (misaligned_o) be_o = 4'b0000;
  end

endmodule

// File: rtl/dm_hs.sv
// Request/response data memory with configurable wait states, byte-lane
// formatting and misalignment rejection.
module dm_hs
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int unsigned DEPTH = dm_words(ADDR_W);

  dm_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dm_op_t            op_q, op_cur;
  logic [ADDR_W-1:0] addr_q, addr_cur;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept, do_access;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rword, wword, ldata;
  logic [3:0]        be;
  logic              misaligned;

  assign accept = (state_q == ST_IDLE) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access edge is the accept edge, so the live
  // inputs must be used there instead of the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_cur   = '{we: we, size: size, sext: sext, wdata: wdata};
      addr_cur = addr;
    end else begin
      op_cur   = op_q;
      addr_cur = addr_q;
    end
  end

  assign do_access = rst_n && (state_d == ST_DONE) && (state_q != ST_DONE);
  assign rword     = mem[addr_cur[ADDR_W-1:BYTE_OFS_W]];

  dm_lane_fmt u_fmt (
    .addr_lo_i    (addr_cur[1:0]),
    .size_i       (op_cur.size),
    .sext_i       (op_cur.sext),
    .wdata_i      (op_cur.wdata),
    .rword_i      (rword),
    .be_o         (be),
    .wword_o      (wword),
    .ldata_o      (ldata),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q   <= op_cur;
        addr_q <= addr;
      end
      if (do_access) begin
        err_q <= misaligned;
        if (!op_cur.we && !misaligned) rdata_q <= ldata;
      end
    end
  end

  // The array carries no reset; be is already zero for rejected accesses.
  always_ff @(posedge clk) begin
    if (do_access && op_cur.we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_cur[ADDR_W-1:BYTE_OFS_W]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign rvalid = (state_q == ST_DONE);
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule
